// File: rtl/rgmii_capture_sched.sv
// ---------------------------------------------------------------------------
// rgmii_capture_sched
//   Controller for the rgm0 RGMII receive port. On an arm pulse it waits for
//   the start of the next frame, assembles RX nibbles (low nibble first) into
//   bytes and stores them in an internal buffer. With PREAMBLE_STRIP set,
//   everything up to and including the first 0xD5 (SFD) is discarded. A dump
//   pulse then streams the held frame to the UART TX byte path, prefixed by
//   its length as a 16-bit big-endian value. The frame stays held afterwards
//   and can be dumped again.
//
// Ports
//   rgm0_clk   in   1         sole clock
//   rgm0_rst   in   1         synchronous active-high reset
//   rgm0_en    in   1         RX data valid
//   rgm0_d     in   4         RX nibble, low nibble of each byte first
//   arm        in   1         pulse: arm capture of the next frame
//   dump       in   1         pulse: transmit the held frame
//   tx_data    out  8         byte to UART transmitter
//   tx_valid   out  1         tx_data valid
//   tx_ready   in   1         UART accepts tx_data this cycle
//   busy       out  1         armed, capturing or dumping
//   frame_rdy  out  1         a captured frame is held
//   overflow   out  1         last capture exceeded the buffer
//   frame_len  out  ADDR_W+1  bytes stored for the last capture
// ---------------------------------------------------------------------------
module rgmii_capture_sched #(
  parameter int ADDR_W         = 11,
  parameter bit PREAMBLE_STRIP = 1'b1
) (
  input  logic              rgm0_clk,
  input  logic              rgm0_rst,
  input  logic              rgm0_en,
  input  logic [3:0]        rgm0_d,
  input  logic              arm,
  input  logic              dump,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_rdy,
  output logic              overflow,
  output logic [ADDR_W:0]   frame_len
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE, ARMED, CAPTURE, HOLD, DUMP_LH, DUMP_LL, DUMP_DATA
  } state_t;

  state_t state, state_next;

  logic            en_q;       // rgm0_en one cycle ago, for edge detection
  logic            phase;      // 1: low nibble already latched
  logic            sfd_seen;
  logic [3:0]      low;
  logic [ADDR_W:0] count;      // bytes stored; MSB set means buffer full
  logic [ADDR_W:0] idx;        // index of the byte currently on tx_data
  logic [ADDR_W:0] idx_next;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      rd_data;

  logic            rise;
  logic            xfer;
  logic            byte_done;
  logic            wr_en;
  logic [7:0]      byte_in;
  logic [15:0]     len16;

  assign rise      = rgm0_en && !en_q;
  assign byte_in   = {rgm0_d, low};
  assign byte_done = (state == CAPTURE) && rgm0_en && phase;
  assign wr_en     = byte_done && (!PREAMBLE_STRIP || sfd_seen) && !count[ADDR_W];
  assign xfer      = tx_valid && tx_ready;
  assign len16     = 16'(frame_len);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge rgm0_clk) begin
    if (rgm0_rst) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; a path that left state_next unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (arm) state_next = ARMED;
      ARMED:     if (rise) state_next = CAPTURE;
      CAPTURE:   if (!rgm0_en) state_next = HOLD;
      HOLD: begin
        // dump has priority over a simultaneous arm
        if (dump)     state_next = DUMP_LH;
        else if (arm) state_next = ARMED;
      end
      DUMP_LH:   if (xfer) state_next = DUMP_LL;
      DUMP_LL:   if (xfer) state_next = (frame_len == '0) ? HOLD : DUMP_DATA;
      DUMP_DATA: if (xfer && (idx + ONE == frame_len)) state_next = HOLD;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from state. tx_data depends only on registers, so it is
  // stable for as long as the state and idx are held by a stall.
  always_comb begin
    busy      = 1'b0;
    frame_rdy = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    unique case (state)
      ARMED, CAPTURE: busy = 1'b1;
      HOLD:           frame_rdy = 1'b1;
      DUMP_LH:   begin busy = 1'b1; tx_valid = 1'b1; tx_data = len16[15:8]; end
      DUMP_LL:   begin busy = 1'b1; tx_valid = 1'b1; tx_data = len16[7:0];  end
      DUMP_DATA: begin busy = 1'b1; tx_valid = 1'b1; tx_data = rd_data;     end
      default: ;
    endcase
  end

  // Read index for the following cycle. The buffer is read with this value so
  // rd_data always equals mem[idx] while dumping, giving one byte per cycle.
  // Outside DUMP_DATA it parks at 0, prefetching the first byte during the
  // length bytes.
  always_comb begin
    idx_next = '0;
    if (state == DUMP_DATA) idx_next = xfer ? idx + ONE : idx;
  end

  // Capture datapath and dump index.
  always_ff @(posedge rgm0_clk) begin
    if (rgm0_rst) begin
      en_q      <= 1'b0;
      phase     <= 1'b0;
      sfd_seen  <= 1'b0;
      low       <= 4'h0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_len <= '0;
      idx       <= '0;
    end else begin
      en_q <= rgm0_en;
      idx  <= idx_next;
      unique case (state)
        ARMED: begin
          overflow <= 1'b0;
          count    <= '0;
          sfd_seen <= 1'b0;
          phase    <= 1'b0;
          // The nibble on the rising edge of rgm0_en is the first of the frame.
          if (rise) begin
            low   <= rgm0_d;
            phase <= 1'b1;
          end
        end
        CAPTURE: begin
          if (rgm0_en) begin
            if (!phase) begin
              low   <= rgm0_d;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (PREAMBLE_STRIP && !sfd_seen) begin
                if (byte_in == 8'hD5) sfd_seen <= 1'b1;
              end else if (count[ADDR_W]) begin
                overflow <= 1'b1;
              end else begin
                count <= count + ONE;
              end
            end
          end else begin
            // End of frame; a pending odd nibble is simply abandoned.
            frame_len <= count;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame buffer with synchronous read.
  // NOTE: the buffer has no reset; contents are only reachable below frame_len,
  // which is always rewritten by a fresh capture before being read.
  always_ff @(posedge rgm0_clk) begin
    if (wr_en) mem[count[ADDR_W-1:0]] <= byte_in;
    rd_data <= mem[idx_next[ADDR_W-1:0]];
  end

endmodule
